// File: rtl/fnd_scan_bcd_if.sv
// ----------------------------------------------------------------------------
// fnd_scan_bcd_if
// Bundles the display-stage signals: the binary count coming from the counter
// stage and the multiplexed 7-segment drive going to the display.
//
//   count    [13:0]  binary value to display (level signal, no handshake)
//   seg_comm [3:0]   digit enables, active low, bit 0 = ones digit
//   seg      [7:0]   segments, active low, bit 7 = dp, bits 6..0 = g..a
//
// Signalling: there is no valid/ready pair. `count` is a plain level that the
// consumer samples every clock; the producer only guarantees that it changes
// rarely relative to the system clock. The display outputs are free-running.
//
// master : the side that drives `count` and watches the display
// slave  : the display stage itself
// ----------------------------------------------------------------------------
interface fnd_scan_bcd_if;
    logic [13:0] count;
    logic [3:0]  seg_comm;
    logic [7:0]  seg;

    modport master (output count, input seg_comm, input seg);
    modport slave  (input count, output seg_comm, output seg);
endinterface

// File: rtl/fnd_scan_bcd.sv
// ----------------------------------------------------------------------------
// fnd_scan_bcd
// Converts a 14-bit binary count (saturated to 9999) into four BCD digits with
// a sequential double-dabble engine and scans them onto a 4-digit
// common-anode 7-segment display.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   bus          fnd_scan_bcd_if.slave: count in, seg_comm/seg out
//   dbg_state_o  converter FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE)
//   dbg_disp_o   display register (four BCD digits, ones in [3:0])
// ----------------------------------------------------------------------------
module fnd_scan_bcd #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int SCAN_HZ       = 1000,
    parameter int DP_DIGIT      = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    fnd_scan_bcd_if.slave        bus,
    output logic [1:0]           dbg_state_o,
    output logic [15:0]          dbg_disp_o
);

    localparam int DIV = (CLK_FREQ / SCAN_HZ > 0) ? CLK_FREQ / SCAN_HZ : 1;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [13:0]   count_s1_q, count_s2_q;
    logic [13:0]   shift_q, shift_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    iter_q, iter_d;
    logic [15:0]   disp_q, disp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    seg_comm_q, seg_comm_d;
    logic [7:0]    seg_q, seg_d;

    logic [15:0]   adj;
    logic [3:0]    upper_zero;
    logic [3:0]    digit;
    logic [7:0]    dec;
    logic          blank_cur;
    logic          dp_on;

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_s1_q <= '0;
            count_s2_q <= '0;
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            disp_q     <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_comm_q <= 4'b1111;
            seg_q      <= 8'hFF;
        end else begin
            count_s1_q <= bus.count;
            count_s2_q <= count_s1_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_comm_q <= seg_comm_d;
            seg_q      <= seg_d;
        end
    end

    // Converter: IDLE loads, 14 SHIFT cycles, DONE publishes -> 16 clocks.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        adj     = bcd_q;
        for (int k = 0; k < 4; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                shift_d = (count_s2_q > 14'd9999) ? 14'd9999 : count_s2_q;
                bcd_d   = '0;
                iter_d  = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Adjusted accumulator and binary shifter move as one 30-bit word.
                {bcd_d, shift_d} = {adj[14:0], shift_q, 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) state_d = DONE;
            end
            DONE: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan prescaler and digit index.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // Output decode works from the current index and display register, so
    // outputs lag an index change by exactly one clock and never skew.
    always_comb begin
        upper_zero    = '0;
        upper_zero[3] = (disp_q[15:12] == 4'd0);
        for (int i = 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
        end
        digit     = disp_q[{idx_q, 2'b00} +: 4];
        dec       = seg_decode(digit);
        blank_cur = (BLANK_LEADING != 0) && (int'(idx_q) > DP_DIGIT) &&
                    (idx_q != 2'd0) && upper_zero[idx_q];
        dp_on     = (int'(idx_q) == DP_DIGIT) && !blank_cur;
        if (blank_cur || dec == 8'hFF) seg_d = 8'hFF;
        else                           seg_d = {~dp_on, dec[6:0]};
        seg_comm_d = ~(4'b0001 << idx_q);
    end

    assign bus.seg_comm = seg_comm_q;
    assign bus.seg      = seg_q;
    assign dbg_state_o  = state_q;
    assign dbg_disp_o   = disp_q;

endmodule

// File: tb/tb_fnd_scan_bcd.sv
// ----------------------------------------------------------------------------
// tb_fnd_scan_bcd
// Bench for fnd_scan_bcd with 4 clocks per digit. Two instances: the default
// display (dp on digit 1, leading-zero blanking) and a plain one (no dp, no
// blanking). Expected scan frames are queued when a count is applied and
// popped one per clock as the display produces them.
// ----------------------------------------------------------------------------
module tb_fnd_scan_bcd;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fnd_scan_bcd_if bus ();
    fnd_scan_bcd_if bus2 ();

    logic [1:0]  st, st2;
    logic [15:0] disp, disp2;

    fnd_scan_bcd #(.CLK_FREQ(1000), .SCAN_HZ(250), .DP_DIGIT(1), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(st), .dbg_disp_o(disp)
    );

    fnd_scan_bcd #(.CLK_FREQ(1000), .SCAN_HZ(250), .DP_DIGIT(4), .BLANK_LEADING(0)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .dbg_state_o(st2), .dbg_disp_o(disp2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [11:0] exp_q[$];
    logic [11:0] exp2_q[$];
    logic [15:0] dexp_q[$];

    typedef struct {
        logic [13:0] cnt;
        logic [15:0] disp;
        logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Posedges since reset release; after posedge n the outputs show index (n-1)/4 mod 4.
    always @(posedge clk) cyc = reset ? 0 : cyc + 1;

    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("scan_main", {20'd0, bus.seg_comm, bus.seg}, {20'd0, e});
        end
        if (exp2_q.size() != 0) begin
            e = exp2_q.pop_front();
            chk("scan_plain", {20'd0, bus2.seg_comm, bus2.seg}, {20'd0, e});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue the next 16 clocks of {seg_comm, seg} for one instance.
    task automatic push_frame(input bit which, input logic [31:0] segs);
        int n;
        int idx;
        logic [3:0] comm;
        for (int c = 0; c < 16; c++) begin
            n    = cyc + 1 + c;
            idx  = ((n - 1) / 4) % 4;
            comm = ~(4'b0001 << idx);
            if (which) exp2_q.push_back({comm, segs[idx*8 +: 8]});
            else       exp_q.push_back({comm, segs[idx*8 +: 8]});
        end
    endtask

    function automatic logic [7:0] seg_model(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] frame_model(input int c, input bit blank_en, input int dp);
        int v;
        int p;
        logic [7:0] s;
        logic [31:0] r;
        v = (c > 9999) ? 9999 : c;
        p = 1;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (blank_en && i > 0 && i > dp && (v / p) == 0) begin
                s = 8'hFF;
            end else begin
                s = seg_model((v / p) % 10);
                if (i == dp) s[7] = 1'b0;
            end
            r[i*8 +: 8] = s;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_model(input int c);
        int v;
        v = (c > 9999) ? 9999 : c;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && b < 40) begin
            tick(1);
            b++;
        end
        if (b >= 40) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int b;
        int r;
        bit prev_done;

        vecs[0] = '{14'd1234,  16'h1234, 32'hF9A43099};
        vecs[1] = '{14'd9999,  16'h9999, 32'h90901090};
        vecs[2] = '{14'd10000, 16'h9999, 32'h90901090};
        vecs[3] = '{14'd16383, 16'h9999, 32'h90901090};
        vecs[4] = '{14'd5,     16'h0005, 32'hFFFF4092};
        vecs[5] = '{14'd105,   16'h0105, 32'hFFF94092};
        vecs[6] = '{14'd0,     16'h0000, 32'hFFFF40C0};
        vecs[7] = '{14'd2000,  16'h2000, 32'hA4C040C0};
        vecs[8] = '{14'd60,    16'h0060, 32'hFFFF02C0};

        // Reset state.
        reset = 1'b1;
        bus.count  = '0;
        bus2.count = '0;
        tick(3);
        chk("rst_comm", {28'd0, bus.seg_comm}, 32'hF);
        chk("rst_seg", {24'd0, bus.seg}, 32'hFF);
        chk("rst_disp", {16'd0, disp}, 32'h0);
        chk("rst_state", {30'd0, st}, 32'd0);

        // First frame after release: "0." on digits 1..0, rest blank.
        reset = 1'b0;
        push_frame(1'b0, 32'hFFFF40C0);
        push_frame(1'b1, 32'hC0C0C0C0);
        drain();

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            bus.count = vecs[i].cnt;
            tick(40);
            chk("disp_vec", {16'd0, disp}, {16'd0, vecs[i].disp});
            push_frame(1'b0, vecs[i].segs);
            drain();
        end

        // Random counts against the bench model.
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 16383);
            bus.count = 14'(r);
            tick(40);
            chk("disp_rand", {16'd0, disp}, {16'd0, bcd_model(r)});
            push_frame(1'b0, frame_model(r, 1'b1, 1));
            drain();
        end

        // Count change while the converter is shifting.
        bus.count = 14'd0;
        tick(40);
        b = 0;
        while (st != 2'd0 && b < 40) begin
            tick(1);
            b++;
        end
        if (b >= 40) chk("idle_timeout", 32'd1, 32'd0);
        tick(2);
        bus.count = 14'd9998;
        dexp_q.push_back(16'h0000);
        dexp_q.push_back(16'h9998);
        prev_done = 1'b0;
        b = 0;
        while (dexp_q.size() != 0 && b < 60) begin
            tick(1);
            b++;
            if (prev_done) chk("disp_seq", {16'd0, disp}, {16'd0, dexp_q.pop_front()});
            prev_done = (st == 2'd2);
        end
        if (dexp_q.size() != 0) chk("done_timeout", 32'd1, 32'd0);

        // No blanking, no dp.
        bus2.count = 14'd7;
        tick(40);
        chk("disp_plain", {16'd0, disp2}, 32'h0007);
        push_frame(1'b1, 32'hC0C0C0F8);
        drain();
        bus2.count = 14'd1234;
        tick(40);
        push_frame(1'b1, 32'hF9A4B099);
        drain();

        // Reset in the middle of operation.
        bus.count = 14'd1234;
        tick(23);
        reset = 1'b1;
        #1;
        chk("midrst_comm", {28'd0, bus.seg_comm}, 32'hF);
        chk("midrst_seg", {24'd0, bus.seg}, 32'hFF);
        chk("midrst_comm2", {28'd0, bus2.seg_comm}, 32'hF);
        tick(3);
        chk("midrst_disp", {16'd0, disp}, 32'h0);
        chk("midrst_state", {30'd0, st}, 32'd0);
        chk("midrst_seg_hold", {24'd0, bus.seg}, 32'hFF);
        reset = 1'b0;
        push_frame(1'b0, 32'hFFFF40C0);
        push_frame(1'b1, 32'hC0C0C0C0);
        drain();
        tick(40);
        chk("post_rst_disp", {16'd0, disp}, 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
